// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART responder.
// Contents: register word indices, STATUS/CTRL bit positions, the TX and RX
// state encodings, and the helper that clamps the baud divisor to its minimum.
package uart_pkg;

    // Register word indices (core address[3:2])
    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_BAUD   = 2'd2;
    localparam logic [1:0] UART_REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_VALID     = 0;
    localparam int ST_RX_OVERRUN   = 1;
    localparam int ST_RX_FRAME_ERR = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_TX_EMPTY     = 4;
    localparam int ST_TX_BUSY      = 5;
    localparam int ST_TX_OVERFLOW  = 6;

    // CTRL bit positions
    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int CTRL_CLR_STICKY = 2;

    // Transmit FSM encoding
    typedef logic [1:0] t_tx_state;
    localparam t_tx_state TX_IDLE  = 2'd0;
    localparam t_tx_state TX_START = 2'd1;
    localparam t_tx_state TX_DATA  = 2'd2;
    localparam t_tx_state TX_STOP  = 2'd3;

    // Receive FSM encoding
    typedef logic [1:0] t_rx_state;
    localparam t_rx_state R_IDLE  = 2'd0;
    localparam t_rx_state R_START = 2'd1;
    localparam t_rx_state R_DATA  = 2'd2;
    localparam t_rx_state R_STOP  = 2'd3;

    // A divisor below 2 would make the half-bit start check degenerate.
    function automatic logic [15:0] eff_divisor(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used as the UART transmit queue.
// Ports: clock/reset (sync, active high); push + wr_data enqueue; pop dequeues
// into the registered rd_data (valid from the edge after pop); full, empty and
// count reflect the current occupancy. A push on a full FIFO is only accepted
// when a pop happens on the same edge; a pop on an empty FIFO is ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rd_data = rd_data_reg;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage has no reset so it maps onto RAM primitives. On a full FIFO a
    // simultaneous push and pop address the same slot; the registered read
    // sees the old entry before the write lands.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (do_pop) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bus_uart_responder.sv
// Memory-mapped UART target on the maxicore32 external bus.
// Ports: clock, reset (sync, active high); sel/address/data_in/data_strobes/
// read/write from the core; data_out (combinational read data, 0 unless
// sel&&read) and bus_error (combinational) back to it; tx serial out (idle
// high) and rx serial in (asynchronous). Register map: 0 DATA, 1 STATUS,
// 2 BAUD, 3 CTRL. TX bytes queue in a FIFO and leave as 8N1 frames; received
// bytes land in a single holding register.
module bus_uart_responder
    import uart_pkg::*;
#(
    parameter int          TX_FIFO_DEPTH   = 16,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic [3:0]  data_strobes,
    input  logic        read,
    input  logic        write,
    output logic        bus_error,
    output logic        tx,
    input  logic        rx
);
    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

    // ---------------- bus decode ----------------
    logic wr_ok, rd_ok, push_req, data_read, clr_sticky;

    assign bus_error = sel && ((read && write) ||
                               (write && address == UART_REG_STATUS) ||
                               (write && data_strobes == 4'b0000));
    // An erroring cycle must leave every register untouched.
    assign wr_ok      = sel && write && !bus_error;
    assign rd_ok      = sel && read && !bus_error;
    assign push_req   = wr_ok && address == UART_REG_DATA && data_strobes[0];
    assign data_read  = rd_ok && address == UART_REG_DATA;
    assign clr_sticky = wr_ok && address == UART_REG_CTRL && data_strobes[0]
                        && data_in[CTRL_CLR_STICKY];

    wire unused_data_bits = ^data_in[31:16];

    // ---------------- BAUD: one register per byte lane ----------------
    wire logic [15:0] baud_value;
    logic [15:0]      eff_baud;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_baud_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    lane_reg <= DEFAULT_DIVISOR[8*gi +: 8];
                end else if (wr_ok && address == UART_REG_BAUD && data_strobes[gi]) begin
                    lane_reg <= data_in[8*gi +: 8];
                end
            end
            assign baud_value[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign eff_baud = eff_divisor(baud_value);

    // ---------------- CTRL ----------------
    logic tx_en_reg, rx_en_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_en_reg <= 1'b0;
            rx_en_reg <= 1'b0;
        end else if (wr_ok && address == UART_REG_CTRL && data_strobes[0]) begin
            tx_en_reg <= data_in[CTRL_TX_EN];
            rx_en_reg <= data_in[CTRL_RX_EN];
        end
    end

    // ---------------- TX FIFO ----------------
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic [CW-1:0] fifo_count;

    uart_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push_req),
        .pop     (fifo_pop),
        .wr_data (data_in[7:0]),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    logic tx_overflow_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_overflow_reg <= 1'b0;
        end else begin
            if (clr_sticky) tx_overflow_reg <= 1'b0;
            if (push_req && fifo_full && !fifo_pop) tx_overflow_reg <= 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    t_tx_state   tx_state_reg;
    logic [15:0] tx_cnt_reg, tx_baud_reg;
    logic [2:0]  tx_bit_reg;
    logic        tx_reg, tx_cnt_done;

    assign tx_cnt_done = (tx_cnt_reg == tx_baud_reg - 16'd1);
    // Popping at the end of STOP chains frames with no idle gap. The popped
    // byte appears on fifo_rd_data one edge later and stays put for the whole
    // frame, because the next pop can only happen at this frame's end.
    assign fifo_pop = tx_en_reg && !fifo_empty &&
                      (tx_state_reg == TX_IDLE || (tx_state_reg == TX_STOP && tx_cnt_done));
    assign tx = tx_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_baud_reg  <= 16'd2;
            tx_bit_reg   <= '0;
            tx_reg       <= 1'b1;
        end else if (fifo_pop) begin
            tx_state_reg <= TX_START;
            tx_cnt_reg   <= '0;
            tx_baud_reg  <= eff_baud;
            tx_reg       <= 1'b0;
        end else if (tx_state_reg != TX_IDLE) begin
            if (!tx_cnt_done) begin
                tx_cnt_reg <= tx_cnt_reg + 16'd1;
            end else begin
                tx_cnt_reg <= '0;
                case (tx_state_reg)
                    TX_START: begin
                        tx_state_reg <= TX_DATA;
                        tx_bit_reg   <= '0;
                        tx_reg       <= fifo_rd_data[0];
                    end
                    TX_DATA: begin
                        if (tx_bit_reg == 3'd7) begin
                            tx_state_reg <= TX_STOP;
                            tx_reg       <= 1'b1;
                        end else begin
                            tx_bit_reg <= tx_bit_reg + 3'd1;
                            tx_reg     <= fifo_rd_data[tx_bit_reg + 3'd1];
                        end
                    end
                    default: begin
                        tx_state_reg <= TX_IDLE;
                        tx_reg       <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- RX synchroniser + FSM ----------------
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    t_rx_state   rx_state_reg;
    logic [15:0] rx_cnt_reg, rx_baud_reg;
    logic [2:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg;
    logic        rx_bit_done, rx_half_done, rx_deliver;

    assign rx_bit_done  = (rx_cnt_reg == rx_baud_reg - 16'd1);
    assign rx_half_done = (rx_cnt_reg == (rx_baud_reg >> 1) - 16'd1);
    assign rx_deliver   = rx_en_reg && rx_state_reg == R_STOP && rx_bit_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !rx_en_reg) begin
            rx_state_reg <= R_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            if (reset) begin
                rx_baud_reg  <= 16'd2;
                rx_shift_reg <= '0;
            end
        end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
            case (rx_state_reg)
                R_IDLE: begin
                    rx_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= R_START;
                        rx_baud_reg  <= eff_baud;
                    end
                end
                R_START: begin
                    // Mid-start check rejects glitches shorter than half a bit.
                    if (rx_half_done) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_sync_reg ? R_IDLE : R_DATA;
                    end
                end
                R_DATA: begin
                    if (rx_bit_done) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7) rx_state_reg <= R_STOP;
                        else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
                    end
                end
                default: begin
                    if (rx_bit_done) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= R_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- RX holding register + sticky flags ----------------
    logic       rx_valid_reg, rx_overrun_reg, rx_frame_err_reg;
    logic [7:0] rx_byte_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_valid_reg     <= 1'b0;
            rx_overrun_reg   <= 1'b0;
            rx_frame_err_reg <= 1'b0;
            rx_byte_reg      <= '0;
        end else begin
            if (clr_sticky) begin
                rx_overrun_reg   <= 1'b0;
                rx_frame_err_reg <= 1'b0;
            end
            if (rx_deliver) begin
                // A DATA read on the same edge frees the holding register.
                if (rx_valid_reg && !data_read) begin
                    rx_overrun_reg <= 1'b1;
                end else begin
                    rx_byte_reg  <= rx_shift_reg;
                    rx_valid_reg <= 1'b1;
                end
                if (!rx_sync_reg) rx_frame_err_reg <= 1'b1;
            end else if (data_read) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    // ---------------- read mux ----------------
    logic [31:0] status_word;

    always_comb begin
        status_word                  = 32'h0;
        status_word[ST_RX_VALID]     = rx_valid_reg;
        status_word[ST_RX_OVERRUN]   = rx_overrun_reg;
        status_word[ST_RX_FRAME_ERR] = rx_frame_err_reg;
        status_word[ST_TX_FULL]      = fifo_full;
        status_word[ST_TX_EMPTY]     = fifo_empty;
        status_word[ST_TX_BUSY]      = (tx_state_reg != TX_IDLE) || (fifo_count != '0);
        status_word[ST_TX_OVERFLOW]  = tx_overflow_reg;
    end

    always_comb begin
        data_out = 32'h0;
        if (sel && read) begin
            case (address)
                UART_REG_DATA:   data_out = {24'h0, rx_byte_reg};
                UART_REG_STATUS: data_out = status_word;
                UART_REG_BAUD:   data_out = {16'h0, baud_value};
                default:         data_out = {30'h0, rx_en_reg, tx_en_reg};
            endcase
        end
    end

endmodule
